// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: one 1-bit shift per clock, start/ready
// handshake in, registered result with a one-cycle done pulse out.
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  input  logic               cancel,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   out
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  // One extra bit so the counter can hold WIDTH itself when it equals 2**SHAMT_W.
  localparam int               CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   work_q;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   out_q;
  logic [CNT_W-1:0]   shamt_ext;
  logic [CNT_W-1:0]   eff_amt;
  logic [WIDTH-1:0]   work_step;

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic [1:0]       sel);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (sel)
      OP_SLL:  return {v[WIDTH-2:0], 1'b0};
      OP_SRL:  return {1'b0, v[WIDTH-1:1]};
      OP_SRA:  return sv >>> 1;
      default: return {v[0], v[WIDTH-1:1]};
    endcase
  endfunction

  // Oversized amounts saturate for the shifts (WIDTH steps already yield the
  // saturated value) and wrap for the rotate.
  always_comb begin
    shamt_ext = {1'b0, shamt};
    eff_amt   = shamt_ext;
    if (op == OP_ROTR) begin
      eff_amt = shamt_ext % WIDTH_C;
    end else if (shamt_ext > WIDTH_C) begin
      eff_amt = WIDTH_C;
    end
  end

  assign work_step = shift1(work_q, op_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (eff_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      op_q   <= OP_SLL;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work_q <= in;
            op_q   <= op;
            cnt_q  <= eff_amt;
            if (eff_amt == '0) begin
              out_q <= in;
            end
          end
        end
        SHIFT: begin
          if (!cancel) begin
            work_q <= work_step;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              out_q <= work_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign out   = out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected result and
// done cycle, an independent monitor checks every done pulse.
module tb_shift_sequencer;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRL  = 2'b01;
  localparam logic [1:0] SRA  = 2'b10;
  localparam logic [1:0] ROTR = 2'b11;

  logic               clk    = 1'b0;
  logic               rst_n  = 1'b0;
  logic               start  = 1'b0;
  logic               cancel = 1'b0;
  logic [1:0]         op     = 2'b00;
  logic [SHAMT_W-1:0] shamt  = '0;
  logic [WIDTH-1:0]   din    = '0;
  logic               ready, busy, done;
  logic [WIDTH-1:0]   dout;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  shift_sequencer #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .shamt  (shamt),
    .in     (din),
    .cancel (cancel),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .out    (dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 out=0x%08h expected no done", dout);
      end else begin
        e = sbq.pop_front();
        check("result", dout, e.val);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("ready_in_done", 32'(ready), 32'd0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(ready && sbq.size() == 0)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: got ready=%0b pending=%0d expected idle", ready, sbq.size());
        sbq.delete();
        return;
      end
    end
  endtask

  // Called at a falling edge; start is held for 1+hold rising edges.
  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                       input logic [31:0] e, input int hold, input logic cx,
                       input bit expect_done);
    wait_idle();
    op     = o;
    shamt  = s;
    din    = d;
    start  = 1'b1;
    cancel = cx;
    if (expect_done) sbq.push_back('{val: e, cyc: cyc + 1 + int'(s)});
    repeat (1 + hold) @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_out",   dout,       32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(SLL,  5'd2,  32'd10,        32'd40,        0, 1'b0, 1'b1);
    issue(SRA,  5'd4,  32'h8000_0000, 32'hF800_0000, 0, 1'b0, 1'b1);
    issue(SRL,  5'd4,  32'h8000_0000, 32'h0800_0000, 0, 1'b0, 1'b1);
    // start still high through the DONE cycle must not launch a second op
    issue(SLL,  5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1'b0, 1'b1);
    issue(ROTR, 5'd1,  32'h0000_0001, 32'h8000_0000, 0, 1'b0, 1'b1);
    issue(ROTR, 5'd8,  32'h1234_5678, 32'h7812_3456, 0, 1'b0, 1'b1);
    issue(SRA,  5'd3,  32'h7000_0000, 32'h0E00_0000, 0, 1'b0, 1'b1);
    // start and cancel together in IDLE: start wins
    issue(SRL,  5'd4,  32'h0000_0100, 32'h0000_0010, 0, 1'b1, 1'b1);

    issue(SLL,  5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("busy_mid_shift", 32'(busy), 32'd1);
    op    = SRL;
    shamt = 5'd1;
    din   = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("out_after_ignored_start", dout, 32'h8000_0000);

    issue(SRL, 5'd8, 32'h0000_00F0, 32'h0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_ready", 32'(ready), 32'd1);
    check("cancel_busy",  32'(busy),  32'd0);
    check("cancel_out",   dout,       32'h8000_0000);
    repeat (12) @(negedge clk);
    check("cancel_out_held", dout, 32'h8000_0000);

    issue(SLL, 5'd16, 32'h0000_0001, 32'h0, 0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out",   dout,       32'h0);
    check("arst_done",  32'(done),  32'd0);
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(SLL, 5'd16, 32'h0000_0001, 32'h0001_0000, 0, 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
